// File: rtl/nios_fprint_oci_pkg.sv
// Shared types and constants for the OCI debug-compressed-trace capture engine.
// The defaults give a 30-bit packed word made of fifteen 2-bit fragments.
package nios_fprint_oci_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } cap_state_e;

    localparam int DEF_FRAG_W         = 2;
    localparam int DEF_FRAGS_PER_WORD = 15;
    localparam int DEF_FIFO_DEPTH     = 16;
    localparam int DEF_CNT_W          = 4;
    localparam int DEF_BUF_W          = DEF_FRAG_W * DEF_FRAGS_PER_WORD;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_BUF_W-1:0] data;
    } dct_entry_t;

endpackage

// File: rtl/nios_fprint_oci_dct_fifo.sv
// Show-ahead synchronous FIFO for packed trace words; the head entry is always
// visible on rdata. A push to a full FIFO is accepted only when a pop frees a slot.
module nios_fprint_oci_dct_fifo
    import nios_fprint_oci_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_W + DEF_BUF_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   level_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign level   = level_q;
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + (PTR_W+1)'(1);
            end else if (pop_ok && !push_ok) begin
                level_q <= level_q - (PTR_W+1)'(1);
            end
        end
    end

    // Storage carries no reset; emptiness is tracked solely by level_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/nios_fprint_oci_dct_capture.sv
// Per-core DCT capture: packs trace fragments LSB-first into words, queues them
// for host readout, and runs the end-of-test flush/stop sequence.
module nios_fprint_oci_dct_capture
    import nios_fprint_oci_pkg::*;
#(
    parameter int FRAG_W         = DEF_FRAG_W,
    parameter int FRAGS_PER_WORD = DEF_FRAGS_PER_WORD,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int DROP_W         = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 frag_valid,
    input  logic [FRAG_W-1:0]                    frag_data,
    input  logic                                 test_ending,
    input  logic                                 test_has_ended,
    input  logic                                 rd_en,
    output logic [FRAG_W*FRAGS_PER_WORD-1:0]     dct_buffer,
    output logic [CNT_W-1:0]                     dct_count,
    output logic                                 word_valid,
    output logic [FRAG_W*FRAGS_PER_WORD-1:0]     word_data,
    output logic [CNT_W-1:0]                     word_count,
    output logic [clog2(FIFO_DEPTH):0]           fifo_level,
    output logic                                 overflow,
    output logic [DROP_W-1:0]                    drop_count,
    output logic                                 done
);

    localparam int BUF_W = FRAG_W * FRAGS_PER_WORD;
    localparam int ENT_W = CNT_W + BUF_W;

    cap_state_e        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_q;

    logic [BUF_W-1:0]  frag_word;
    logic [CNT_W-1:0]  cnt_inc;
    logic              push;
    logic [BUF_W-1:0]  push_data;
    logic [CNT_W-1:0]  push_cnt;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_rdata;

    // The target slot is always zero because the assembly clears after each word.
    assign frag_word = BUF_W'(frag_data) << (int'(cnt_q) * FRAG_W);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign pop       = rd_en && !fifo_empty;
    assign drop      = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            buf_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end
        end
    end

    // test_has_ended wins over everything and freezes the assembly for inspection.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = buf_q;
        push_cnt  = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (test_has_ended) begin
                    state_d = ST_DONE;
                end else begin
                    if (frag_valid) begin
                        if (cnt_inc == CNT_W'(FRAGS_PER_WORD)) begin
                            push      = 1'b1;
                            push_data = buf_q | frag_word;
                            push_cnt  = cnt_inc;
                            buf_d     = '0;
                            cnt_d     = '0;
                        end else begin
                            buf_d = buf_q | frag_word;
                            cnt_d = cnt_inc;
                        end
                    end
                    if (test_ending) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (test_has_ended) begin
                    state_d = ST_DONE;
                end else begin
                    push    = (cnt_q != '0);
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    nios_fprint_oci_dct_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({push_cnt, push_data}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign word_valid = !fifo_empty;
    assign word_data  = word_valid ? fifo_rdata[BUF_W-1:0] : '0;
    assign word_count = word_valid ? fifo_rdata[ENT_W-1:BUF_W] : '0;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_nios_fprint_oci_dct_capture.sv
// Directed bench for the DCT capture engine: a queue scoreboard holds the words
// the bench expects in the FIFO, alongside a small procedural capture model.
module tb_nios_fprint_oci_dct_capture;

    localparam int DEPTH   = 16;
    localparam int M_RUN   = 0;
    localparam int M_FLUSH = 1;
    localparam int M_DONE  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frag_valid;
    logic [1:0]  frag_data;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_en;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        word_valid;
    logic [29:0] word_data;
    logic [3:0]  word_count;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        done;

    nios_fprint_oci_dct_capture #(
        .FRAG_W         (2),
        .FRAGS_PER_WORD (15),
        .CNT_W          (4),
        .FIFO_DEPTH     (16),
        .DROP_W         (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frag_valid     (frag_valid),
        .frag_data      (frag_data),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_en          (rd_en),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_count     (word_count),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cnt;
        logic [29:0] data;
    } expEnt_t;

    expEnt_t     expQ[$];
    logic [29:0] mAsm;
    int          mCnt;
    int          mState;
    logic        mOverflow;
    int          mDrops;
    int          compared = 0;
    int          mismatched = 0;

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkVal("dct_count", 64'(dct_count), 64'(mCnt));
        checkVal("dct_buffer", 64'(dct_buffer), 64'(mAsm));
        checkVal("fifo_level", 64'(fifo_level), 64'(expQ.size()));
        checkVal("word_valid", 64'(word_valid), 64'(expQ.size() != 0));
        checkVal("overflow", 64'(overflow), 64'(mOverflow));
        checkVal("drop_count", 64'(drop_count), 64'(mDrops));
        checkVal("done", 64'(done), 64'(mState == M_DONE));
        if (expQ.size() > 0) begin
            checkVal("word_data", 64'(word_data), 64'(expQ[0].data));
            checkVal("word_count", 64'(word_count), 64'(expQ[0].cnt));
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [1:0] fd, input logic te,
                                 input logic the, input logic rd);
        expEnt_t ent;
        bit      pushNow;
        frag_valid     = fv;
        frag_data      = fd;
        test_ending    = te;
        test_has_ended = the;
        rd_en          = rd;
        pushNow        = 0;
        ent            = '0;
        case (mState)
            M_RUN: begin
                if (the) begin
                    mState = M_DONE;
                end else begin
                    if (fv) begin
                        mAsm[mCnt*2 +: 2] = fd;
                        mCnt++;
                        if (mCnt == 15) begin
                            pushNow  = 1;
                            ent.cnt  = 4'd15;
                            ent.data = mAsm;
                            mAsm     = '0;
                            mCnt     = 0;
                        end
                    end
                    if (te) mState = M_FLUSH;
                end
            end
            M_FLUSH: begin
                if (the) begin
                    mState = M_DONE;
                end else begin
                    if (mCnt > 0) begin
                        pushNow  = 1;
                        ent.cnt  = 4'(mCnt);
                        ent.data = mAsm;
                    end
                    mAsm   = '0;
                    mCnt   = 0;
                    mState = M_DONE;
                end
            end
            default: ;
        endcase
        if (rd && expQ.size() > 0) void'(expQ.pop_front());
        if (pushNow) begin
            if (expQ.size() < DEPTH) begin
                expQ.push_back(ent);
            end else begin
                mOverflow = 1'b1;
                if (mDrops < 255) mDrops++;
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        reset_n        = 1'b0;
        frag_valid     = 1'b1;
        frag_data      = 2'd3;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_en          = 1'b0;
        expQ.delete();
        mAsm      = '0;
        mCnt      = 0;
        mState    = M_RUN;
        mOverflow = 1'b0;
        mDrops    = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput();
        checkVal("rst_word_data", 64'(word_data), 64'(0));
        checkVal("rst_word_count", 64'(word_count), 64'(0));
    endtask

    task automatic sendPattern(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 2'(k % 4), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendWord(input logic rd);
        for (int k = 0; k < 15; k++) applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, rd);
    endtask

    initial begin
        reset_n = 1'b0;
        frag_valid = 1'b0;
        frag_data = 2'd0;
        test_ending = 1'b0;
        test_has_ended = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        doReset();

        // Full word of the k mod 4 pattern, then pop it and pop once more while empty.
        sendPattern(15);
        checkVal("pattern_valid", 64'(word_valid), 64'(1));
        checkVal("pattern_word", 64'(word_data), 64'(30'h24E4E4E4));
        checkVal("pattern_count", 64'(word_count), 64'(15));
        checkVal("pattern_dct_count", 64'(dct_count), 64'(0));
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        checkVal("empty_pop_level", 64'(fifo_level), 64'(0));

        // Fill, then push and pop together at full, then overflow and saturate.
        doReset();
        repeat (16) sendWord(1'b0);
        checkVal("full_level", 64'(fifo_level), 64'(16));
        for (int k = 0; k < 14; k++) applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        checkVal("pushpop_level", 64'(fifo_level), 64'(16));
        checkVal("pushpop_overflow", 64'(overflow), 64'(0));
        sendWord(1'b0);
        checkVal("drop_overflow", 64'(overflow), 64'(1));
        checkVal("drop_count_1", 64'(drop_count), 64'(1));
        repeat (260) sendWord(1'b0);
        checkVal("drop_saturate", 64'(drop_count), 64'(255));
        repeat (17) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        checkVal("drain_level", 64'(fifo_level), 64'(0));

        // Partial word flushed by test_ending; fragments in FLUSH and DONE are ignored.
        doReset();
        sendPattern(7);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        checkVal("flush_done", 64'(done), 64'(1));
        checkVal("flush_count", 64'(word_count), 64'(7));
        checkVal("flush_word", 64'(word_data), 64'(30'h000024E4));
        checkVal("flush_high_zero", 64'(word_data >> 14), 64'(0));
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        checkVal("done_drain", 64'(fifo_level), 64'(0));

        // test_ending together with the completing fragment: one word, empty flush.
        doReset();
        sendPattern(14);
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checkVal("te_complete_level", 64'(fifo_level), 64'(1));
        checkVal("te_complete_done", 64'(done), 64'(1));

        // test_has_ended beats test_ending and a fragment; assembly is frozen.
        doReset();
        repeat (3) sendWord(1'b0);
        sendPattern(5);
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        checkVal("he_done", 64'(done), 64'(1));
        checkVal("he_dct_count", 64'(dct_count), 64'(5));
        checkVal("he_dct_buffer", 64'(dct_buffer), 64'(30'h000000E4));
        checkVal("he_level", 64'(fifo_level), 64'(3));
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        checkVal("he_ignored", 64'(dct_count), 64'(5));

        // Reset mid-word with words queued, then capture restarts cleanly.
        doReset();
        repeat (3) sendWord(1'b0);
        sendPattern(4);
        doReset();
        checkVal("midrst_level", 64'(fifo_level), 64'(0));
        checkVal("midrst_count", 64'(dct_count), 64'(0));
        checkVal("midrst_done", 64'(done), 64'(0));
        sendPattern(15);
        checkVal("restart_word", 64'(word_data), 64'(30'h24E4E4E4));
        checkVal("restart_level", 64'(fifo_level), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
